// File: rtl/hamming_pkg.sv
// Shared SECDED Hamming helpers: width derivation, encoder and decoder.
// The functions run on the widest supported word; callers zero-pad and truncate.
package hamming_pkg;

  localparam int MAX_DATA_WIDTH = 64;
  localparam int MAX_CODE_WIDTH = 72;

  typedef enum logic [1:0] {
    DEC_CLEAN,
    DEC_SEC,
    DEC_DED
  } ham_status_e;

  typedef struct packed {
    logic [MAX_DATA_WIDTH-1:0] data;
    logic                      sec;
    logic                      ded;
  } ham_dec_t;

  function automatic int calc_parity_bits(input int dataWidth);
    return $clog2(dataWidth) + 1;
  endfunction

  function automatic int calc_code_width(input int dataWidth);
    return dataWidth + calc_parity_bits(dataWidth) + 1;
  endfunction

  function automatic logic is_pow2(input int v);
    return (v & (v - 1)) == 0;
  endfunction

  // Parity bit 2^i equals bit i of the XOR of all set data-bit positions.
  function automatic logic [MAX_CODE_WIDTH-1:0] ham_encode(input logic [MAX_DATA_WIDTH-1:0] data,
                                                           input int dataWidth);
    logic [MAX_CODE_WIDTH-1:0] cw;
    logic [6:0] syn;
    logic [6:0] idx;
    logic [6:0] di;
    int hamLen;
    hamLen = dataWidth + calc_parity_bits(dataWidth);
    cw  = '0;
    syn = '0;
    di  = '0;
    for (int pos = 1; pos < MAX_CODE_WIDTH; pos++) begin
      idx = 7'(pos);
      if (pos <= hamLen && !is_pow2(pos)) begin
        cw[idx - 7'd1] = data[di[5:0]];
        if (data[di[5:0]]) syn = syn ^ idx;
        di = di + 7'd1;
      end
    end
    for (int i = 0; i < 7; i++) begin
      idx = 7'(1 << i);
      if (int'(idx) <= hamLen) cw[idx - 7'd1] = syn[3'(i)];
    end
    cw[7'(hamLen)] = ^cw;
    return cw;
  endfunction

  function automatic ham_dec_t ham_decode(input logic [MAX_CODE_WIDTH-1:0] cw,
                                          input int dataWidth);
    ham_dec_t res;
    ham_status_e status;
    logic [MAX_CODE_WIDTH-1:0] fixedCw;
    logic [6:0] syn;
    logic [6:0] idx;
    logic [6:0] di;
    logic par;
    int hamLen;
    hamLen = dataWidth + calc_parity_bits(dataWidth);
    syn = '0;
    par = ^cw;
    for (int pos = 1; pos < MAX_CODE_WIDTH; pos++) begin
      idx = 7'(pos);
      if (pos <= hamLen && cw[idx - 7'd1]) syn = syn ^ idx;
    end
    fixedCw = cw;
    // An odd error count with a syndrome beyond the code length cannot be a single error.
    if (syn == '0 && !par) begin
      status = DEC_CLEAN;
    end else if (par && syn == '0) begin
      status = DEC_SEC;
    end else if (par && int'(syn) <= hamLen) begin
      fixedCw[syn - 7'd1] = ~fixedCw[syn - 7'd1];
      status = DEC_SEC;
    end else begin
      status = DEC_DED;
    end
    res.data = '0;
    di = '0;
    for (int pos = 1; pos < MAX_CODE_WIDTH; pos++) begin
      idx = 7'(pos);
      if (pos <= hamLen && !is_pow2(pos)) begin
        res.data[di[5:0]] = fixedCw[idx - 7'd1];
        di = di + 7'd1;
      end
    end
    res.sec = (status == DEC_SEC);
    res.ded = (status == DEC_DED);
    return res;
  endfunction

endpackage

// File: rtl/hamming_secded_pipe_lane.sv
// One lane: encode plus error injection in S1, SECDED decode into S2.
// HAMMING_ERR_CNT_EN adds saturating per-lane SEC/DED counters.
module hamming_lane
  import hamming_pkg::*;
#(
  parameter int DATA_WIDTH = 8
`ifdef HAMMING_ERR_CNT_EN
  ,parameter int CNT_WIDTH = 16
`endif
  ,localparam int CODE_WIDTH = calc_code_width(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [CODE_WIDTH-1:0] errMask_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [CODE_WIDTH-1:0] codeword_o,
  output logic                  sec_o,
  output logic                  ded_o
`ifdef HAMMING_ERR_CNT_EN
  ,input  logic                 cntClr_i
  ,output logic [CNT_WIDTH-1:0] secCnt_o
  ,output logic [CNT_WIDTH-1:0] dedCnt_o
`endif
);

  logic                      v1_q, v1_d, v2_q, v2_d;
  logic [CODE_WIDTH-1:0]     cw1_q, cw1_d, cw2_q, cw2_d;
  logic [DATA_WIDTH-1:0]     data2_q, data2_d;
  logic                      sec2_q, sec2_d, ded2_q, ded2_d;
  logic [MAX_DATA_WIDTH-1:0] dataExt;
  logic [MAX_CODE_WIDTH-1:0] cwExt;
  ham_dec_t                  dec;
  logic                      adv1, adv2, accept;

  always_comb begin
    dataExt = '0;
    dataExt[DATA_WIDTH-1:0] = data_i;
    cwExt = '0;
    cwExt[CODE_WIDTH-1:0] = cw1_q;
    dec = ham_decode(cwExt, DATA_WIDTH);
  end

  // Reset blocks acceptance so no word enters while the pipe is being flushed.
  always_comb begin
    adv2    = !v2_q | ready_i;
    adv1    = !v1_q | adv2;
    ready_o = !rst_i & adv1;
    accept  = valid_i & ready_o;
  end

  always_comb begin
    v1_d  = v1_q;
    cw1_d = cw1_q;
    if (accept) begin
      v1_d  = 1'b1;
      cw1_d = CODE_WIDTH'(ham_encode(dataExt, DATA_WIDTH)) ^ errMask_i;
    end else if (adv1) begin
      v1_d = 1'b0;
    end
  end

  always_comb begin
    v2_d    = v2_q;
    cw2_d   = cw2_q;
    data2_d = data2_q;
    sec2_d  = sec2_q;
    ded2_d  = ded2_q;
    if (v1_q && adv2) begin
      v2_d    = 1'b1;
      cw2_d   = cw1_q;
      data2_d = DATA_WIDTH'(dec.data);
      sec2_d  = dec.sec;
      ded2_d  = dec.ded;
    end else if (ready_i) begin
      v2_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1_q    <= 1'b0;
      cw1_q   <= '0;
      v2_q    <= 1'b0;
      cw2_q   <= '0;
      data2_q <= '0;
      sec2_q  <= 1'b0;
      ded2_q  <= 1'b0;
    end else begin
      v1_q    <= v1_d;
      cw1_q   <= cw1_d;
      v2_q    <= v2_d;
      cw2_q   <= cw2_d;
      data2_q <= data2_d;
      sec2_q  <= sec2_d;
      ded2_q  <= ded2_d;
    end
  end

  assign valid_o    = v2_q;
  assign data_o     = data2_q;
  assign codeword_o = cw2_q;
  assign sec_o      = sec2_q;
  assign ded_o      = ded2_q;

`ifdef HAMMING_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] secCnt_q, secCnt_d, dedCnt_q, dedCnt_d;
  logic                 outHs;

  // Counting happens on the output handshake; a clear request overrides it.
  always_comb begin
    outHs    = v2_q & ready_i;
    secCnt_d = secCnt_q;
    dedCnt_d = dedCnt_q;
    if (cntClr_i) begin
      secCnt_d = '0;
      dedCnt_d = '0;
    end else begin
      if (outHs && sec2_q && !(&secCnt_q)) secCnt_d = secCnt_q + CNT_WIDTH'(1);
      if (outHs && ded2_q && !(&dedCnt_q)) dedCnt_d = dedCnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      secCnt_q <= '0;
      dedCnt_q <= '0;
    end else begin
      secCnt_q <= secCnt_d;
      dedCnt_q <= dedCnt_d;
    end
  end

  assign secCnt_o = secCnt_q;
  assign dedCnt_o = dedCnt_q;
`endif

endmodule

// File: rtl/hamming_secded_pipe.sv
// Multi-lane registered SECDED encode / error-inject / decode datapath.
// Optional HAMMING_ERR_CNT_EN build adds per-lane error counters.
module hamming_secded_pipe
  import hamming_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PORTS  = 2,
  parameter int CNT_WIDTH  = 16,
  localparam int PARITY_BITS = calc_parity_bits(DATA_WIDTH),
  localparam int CODE_WIDTH  = DATA_WIDTH + PARITY_BITS + 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_PORTS-1:0]            i_valid,
  output logic [NUM_PORTS-1:0]            o_ready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_data,
  input  logic [NUM_PORTS*CODE_WIDTH-1:0] i_err_mask,
  output logic [NUM_PORTS-1:0]            o_valid,
  input  logic [NUM_PORTS-1:0]            i_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] o_data,
  output logic [NUM_PORTS*CODE_WIDTH-1:0] o_codeword,
  output logic [NUM_PORTS-1:0]            o_sec,
  output logic [NUM_PORTS-1:0]            o_ded
`ifdef HAMMING_ERR_CNT_EN
  ,input  logic                           i_cnt_clr
  ,output logic [NUM_PORTS*CNT_WIDTH-1:0] o_sec_cnt
  ,output logic [NUM_PORTS*CNT_WIDTH-1:0] o_ded_cnt
`endif
);

  if (!(DATA_WIDTH == 4 || DATA_WIDTH == 8 || DATA_WIDTH == 16 ||
        DATA_WIDTH == 32 || DATA_WIDTH == 64) || NUM_PORTS < 1 || CNT_WIDTH < 1) begin : gBadConfig
    $error("hamming_secded_pipe: unsupported parameter combination");
  end

  for (genvar k = 0; k < NUM_PORTS; k++) begin : gLane
    hamming_lane #(
      .DATA_WIDTH (DATA_WIDTH)
`ifdef HAMMING_ERR_CNT_EN
      ,.CNT_WIDTH (CNT_WIDTH)
`endif
    ) uLane (
      .clk_i      (i_clk),
      .rst_i      (i_rst),
      .valid_i    (i_valid[k]),
      .ready_o    (o_ready[k]),
      .data_i     (i_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .errMask_i  (i_err_mask[k*CODE_WIDTH +: CODE_WIDTH]),
      .valid_o    (o_valid[k]),
      .ready_i    (i_ready[k]),
      .data_o     (o_data[k*DATA_WIDTH +: DATA_WIDTH]),
      .codeword_o (o_codeword[k*CODE_WIDTH +: CODE_WIDTH]),
      .sec_o      (o_sec[k]),
      .ded_o      (o_ded[k])
`ifdef HAMMING_ERR_CNT_EN
      ,.cntClr_i  (i_cnt_clr)
      ,.secCnt_o  (o_sec_cnt[k*CNT_WIDTH +: CNT_WIDTH])
      ,.dedCnt_o  (o_ded_cnt[k*CNT_WIDTH +: CNT_WIDTH])
`endif
    );
  end

endmodule
